// File: rtl/enigma_ctrl_pkg.sv
// Shared types and constants for the Enigma stream sequencer.
package enigma_ctrl_pkg;

    // Sequencer states, one per phase of handling a single character
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WAIT   = 3'd2,
        SETTLE = 3'd3,
        OUT    = 3'd4,
        STEP   = 3'd5,
        NEXT   = 3'd6,
        DONE   = 3'd7
    } state_e;

    // ASCII landmarks used for letter detection and case folding
    localparam logic [7:0] CH_A     = 8'd65;
    localparam logic [7:0] CH_Z     = 8'd90;
    localparam logic [7:0] CH_a     = 8'd97;
    localparam logic [7:0] CH_z     = 8'd122;
    localparam logic [7:0] CASE_OFS = 8'd32;

    // Width of the settle counter; covers settle times of 1..15 cycles
    localparam int unsigned SETTLE_W = 4;

endpackage : enigma_ctrl_pkg

// File: rtl/enigma_char_classify.sv
// Combinational character classifier: flags letters and folds lower case
// onto upper case so the machine only ever sees 'A'..'Z' for letters.
module enigma_char_classify
    import enigma_ctrl_pkg::*;
(
    input  logic [7:0] char_in,
    output logic       is_letter,
    output logic [7:0] upper_char
);

    // Classify the character and produce its upper-case form
    always_comb begin
        is_letter  = 1'b0;
        upper_char = char_in;
        if ((char_in >= CH_a) && (char_in <= CH_z)) begin
            is_letter  = 1'b1;
            upper_char = char_in - CASE_OFS;
        end else if ((char_in >= CH_A) && (char_in <= CH_Z)) begin
            is_letter  = 1'b1;
            upper_char = char_in;
        end else begin
            is_letter  = 1'b0;
            upper_char = char_in;
        end
    end

endmodule : enigma_char_classify

// File: rtl/enigma_stream_sequencer.sv
// Drives an external EnigmaMachine across a message: loads the start
// positions, feeds one character per input handshake, waits for the
// machine output to settle, hands the result downstream and steps the
// rotors after every letter. All outputs come straight from flops.
module enigma_stream_sequencer
    import enigma_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 1,
    parameter int unsigned LEN_W          = 8,
    parameter bit          STEP_NONLETTER = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [4:0]       pos1In,
    input  logic [4:0]       pos2In,
    input  logic [4:0]       pos3In,
    input  logic [LEN_W-1:0] msgLen,
    input  logic [7:0]       inChar,
    input  logic             inValid,
    output logic             inReady,
    output logic [7:0]       outChar,
    output logic             outValid,
    input  logic             outReady,
    output logic [7:0]       engChar,
    output logic [4:0]       engPos1,
    output logic [4:0]       engPos2,
    output logic [4:0]       engPos3,
    output logic             engLoad,
    output logic             engStep,
    input  logic [7:0]       engOut,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] charCount
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [LEN_W-1:0]    LEN_ONE     = LEN_W'(1);
    localparam logic [LEN_W-1:0]    LEN_ZERO    = LEN_W'(0);

    state_e              state_q, state_d, nxt_state_s;
    logic [4:0]          pos1_q, pos1_d, pos2_q, pos2_d, pos3_q, pos3_d;
    logic [LEN_W-1:0]    msg_len_q, msg_len_d;
    logic [LEN_W-1:0]    count_q, count_d, count_inc_s;
    logic [7:0]          eng_char_q, eng_char_d;
    logic [7:0]          raw_char_q, raw_char_d;
    logic                letter_q, letter_d;
    logic [7:0]          out_char_q, out_char_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                eng_load_q, eng_load_d;
    logic                eng_step_q, eng_step_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cls_letter_s;
    logic [7:0]          cls_upper_s;

    enigma_char_classify u_classify (
        .char_in    (inChar),
        .is_letter  (cls_letter_s),
        .upper_char (cls_upper_s)
    );

    assign count_inc_s = count_q + LEN_ONE;

    // Next-state and datapath updates; abort overrides every transition
    always_comb begin
        nxt_state_s = state_q;
        pos1_d      = pos1_q;
        pos2_d      = pos2_q;
        pos3_d      = pos3_q;
        msg_len_d   = msg_len_q;
        count_d     = count_q;
        eng_char_d  = eng_char_q;
        raw_char_d  = raw_char_q;
        letter_d    = letter_q;
        out_char_d  = out_char_q;
        settle_d    = settle_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pos1_d      = pos1In;
                    pos2_d      = pos2In;
                    pos3_d      = pos3In;
                    msg_len_d   = msgLen;
                    count_d     = LEN_ZERO;
                    nxt_state_s = LOAD;
                end else begin
                    nxt_state_s = IDLE;
                end
            end
            LOAD: begin
                if (msg_len_q == LEN_ZERO) begin
                    nxt_state_s = DONE;
                end else begin
                    nxt_state_s = WAIT;
                end
            end
            WAIT: begin
                if (inValid) begin
                    eng_char_d  = cls_upper_s;
                    raw_char_d  = inChar;
                    letter_d    = cls_letter_s;
                    settle_d    = {SETTLE_W{1'b0}};
                    nxt_state_s = SETTLE;
                end else begin
                    nxt_state_s = WAIT;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    // Non-letters pass through untouched, the machine output is ignored
                    out_char_d  = letter_q ? engOut : raw_char_q;
                    settle_d    = {SETTLE_W{1'b0}};
                    nxt_state_s = OUT;
                end else begin
                    settle_d    = settle_q + SETTLE_ONE;
                    nxt_state_s = SETTLE;
                end
            end
            OUT: begin
                if (outReady) begin
                    if (letter_q || STEP_NONLETTER) begin
                        nxt_state_s = STEP;
                    end else begin
                        nxt_state_s = NEXT;
                    end
                end else begin
                    nxt_state_s = OUT;
                end
            end
            STEP: begin
                nxt_state_s = NEXT;
            end
            NEXT: begin
                count_d = count_inc_s;
                if (count_inc_s == msg_len_q) begin
                    nxt_state_s = DONE;
                end else begin
                    nxt_state_s = WAIT;
                end
            end
            DONE: begin
                nxt_state_s = IDLE;
            end
            default: begin
                nxt_state_s = IDLE;
            end
        endcase

        if (abort) begin
            state_d = IDLE;
        end else begin
            state_d = nxt_state_s;
        end

        // Output strobes are decoded from the upcoming state so they are registered
        in_ready_d  = (state_d == WAIT);
        out_valid_d = (state_d == OUT);
        eng_load_d  = (state_d == LOAD);
        eng_step_d  = (state_d == STEP);
        done_d      = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State, datapath and output registers with asynchronous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pos1_q      <= 5'd0;
            pos2_q      <= 5'd0;
            pos3_q      <= 5'd0;
            msg_len_q   <= LEN_ZERO;
            count_q     <= LEN_ZERO;
            eng_char_q  <= 8'd0;
            raw_char_q  <= 8'd0;
            letter_q    <= 1'b0;
            out_char_q  <= 8'd0;
            settle_q    <= {SETTLE_W{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            eng_load_q  <= 1'b0;
            eng_step_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos1_q      <= pos1_d;
            pos2_q      <= pos2_d;
            pos3_q      <= pos3_d;
            msg_len_q   <= msg_len_d;
            count_q     <= count_d;
            eng_char_q  <= eng_char_d;
            raw_char_q  <= raw_char_d;
            letter_q    <= letter_d;
            out_char_q  <= out_char_d;
            settle_q    <= settle_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            eng_load_q  <= eng_load_d;
            eng_step_q  <= eng_step_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign inReady   = in_ready_q;
    assign outChar   = out_char_q;
    assign outValid  = out_valid_q;
    assign engChar   = eng_char_q;
    assign engPos1   = pos1_q;
    assign engPos2   = pos2_q;
    assign engPos3   = pos3_q;
    assign engLoad   = eng_load_q;
    assign engStep   = eng_step_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign charCount = count_q;

endmodule : enigma_stream_sequencer
